pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the MINA CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  It carries a WIDTH-bit payload, typically a packed *_params_t struct.
//  It adds a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
//  Empty slots present a bubble payload (RESET_VALUE, e.g. MEM_OP_NONE encoding).
// PARAMETERS
//  WIDTH        64    payload width in bits (>=1)
//  RESET_VALUE  '0    payload driven on out_data whenever out_valid=0 (bubble/NOP encoding)
//  SKID         1     1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  flush       in   1      synchronous kill of all held entries and of the current input
//  in_valid    in   1      upstream payload valid
//  in_ready    out  1      stage can accept in_data this cycle
//  in_data     in   WIDTH  upstream payload
//  out_valid   out  1      out_data holds a real entry
//  out_ready   in   1      downstream accepts out_data this cycle
//  out_data    out  WIDTH  oldest held entry, or RESET_VALUE when empty
//  occupancy   out  2      entries held: 0..2 (SKID=0: 0..1)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): out_valid=0, out_data=RESET_VALUE, occupancy=0, skid slot invalid.
//    in_ready=1 for SKID=1; in_ready=1 for SKID=0, since the stage is empty.
//    Handshakes are ignored while rst_n=0. Assertion mid-transfer discards all held entries immediately.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both are sampled at the rising edge.
//  - Latency: an accepted entry appears on out_data the cycle after the push. Throughput is 1 per cycle.
//  - Ordering is strict FIFO. No entry is duplicated or dropped except by flush or reset.
//  - Stability: while out_valid=1 and out_ready=0, out_valid and out_data hold unchanged.
//  - Invariant: out_valid=0 implies out_data==RESET_VALUE. This holds after a pop that leaves the stage empty, and after flush.
//  - SKID=1 FSM (occupancy = state):
//      EMPTY: push -> ONE (main<=in_data).
//      ONE:   push&pop -> ONE (main<=in_data); pop only -> EMPTY; push only -> FULL (skid<=in_data).
//      FULL:  pop -> ONE (main<=skid, skid cleared); no pop -> FULL.
//    In FULL, push is impossible because in_ready=0.
//    in_ready is a flop: next in_ready = (next state != FULL). It never depends combinationally on out_ready.
//    After a pop from FULL, in_ready rises on the following cycle.
//  - SKID=0: single main register.
//    in_ready = ~out_valid | out_ready, combinational.
//    push&pop in the same cycle replaces main.
//    occupancy[1] is tied to 0.
//  - Flush has priority over push and pop.
//    At the edge where flush=1, all entries are invalidated: occupancy=0, out_valid=0, out_data=RESET_VALUE.
//    in_data in the flush cycle is dropped even if in_ready=1.
//    A pop coinciding with flush still counts as consumed by downstream. The stage does not retry it.
//    in_ready is 1 on the cycle after the flush.
//  - No X propagation: skid and main registers are reset.
//    in_data is captured only on push, so idle X inputs never reach out_data.
// TESTING
//  1. Reset: pulse rst_n=0 asynchronously while occupancy=2 -> out_valid=0, out_data=RESET_VALUE, occupancy=0 before the next edge.
//  2. Streaming (SKID=1): out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, lagging by 1, in_ready stays 1.
//  3. Backpressure: out_ready=0, offer 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 after the 2nd push, occupancy=2, out_data=0xA stable.
//     Then raise out_ready -> 0xA,0xB,0xC delivered in order, in_ready rises one cycle after the first pop.
//  4. Flush: occupancy=2, in_valid=1 with 0xD, flush=1 for one cycle -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, 0xD never output.
//  5. SKID=0 comb ready: occupancy=1, out_ready=0 -> in_ready=0.
//     Raise out_ready with in_valid=1, 0x5 -> in_ready=1 the same cycle, 0x5 on out_data next cycle, occupancy stays 1.
//  6. Bubble invariant: random valid/ready/flush for 10k cycles against a scoreboard -> FIFO order kept, no loss or duplication, out_valid=0 always implies out_data==RESET_VALUE.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// The upstream/downstream controller drives the master side; the stage is the slave.
interface pipe_stage_if #(
  parameter int WIDTH = 64
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and optional 2-entry skid buffer. Empty slots present RESET_VALUE as a bubble.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, out_data=RESET_VALUE
// ONE   | oldest entry in main, skid slot empty
// FULL  | main and skid both hold entries, in_ready=0 (SKID=1 only)
module pipe_stage_reg #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;
  logic             push;
  logic             pop;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

  // The skid variant registers in_ready so it never depends on out_ready.
  assign bus.in_ready = SKID ? rdy_q : (~bus.out_valid | bus.out_ready);

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      rdy_q   <= 1'b1;
    end else if (bus.flush) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_q  <= bus.in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= bus.in_data;
          end else if (pop) begin
            main_q  <= RESET_VALUE;
            state_q <= EMPTY;
          end else if (push && SKID) begin
            skid_q  <= bus.in_data;
            state_q <= FULL;
            rdy_q   <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            skid_q  <= RESET_VALUE;
            state_q <= ONE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          main_q  <= RESET_VALUE;
          skid_q  <= RESET_VALUE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg in both SKID=1 and SKID=0 builds.
module tb_pipe_stage_reg;
  localparam int          W  = 16;
  localparam logic [W-1:0] RV = 16'hDEAD;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_stage_if #(.WIDTH(W)) if_a ();
  pipe_stage_if #(.WIDTH(W)) if_b ();

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         x_rdy;
    logic         x_ov;
    logic [W-1:0] x_od;
    logic [1:0]   x_occ;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(logic fl, logic iv, logic [W-1:0] d, logic ordy,
                              logic x_rdy, logic x_ov, logic [W-1:0] x_od, logic [1:0] x_occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_od = x_od; v.x_occ = x_occ;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit sel, logic fl, logic iv, logic [W-1:0] d, logic ordy);
    if (sel) begin
      if_b.flush = fl; if_b.in_valid = iv; if_b.in_data = d; if_b.out_ready = ordy;
    end else begin
      if_a.flush = fl; if_a.in_valid = iv; if_a.in_data = d; if_a.out_ready = ordy;
    end
  endtask

  function automatic logic g_rdy(bit sel);
    return sel ? if_b.in_ready : if_a.in_ready;
  endfunction
  function automatic logic g_ov(bit sel);
    return sel ? if_b.out_valid : if_a.out_valid;
  endfunction
  function automatic logic [W-1:0] g_od(bit sel);
    return sel ? if_b.out_data : if_a.out_data;
  endfunction
  function automatic logic [1:0] g_occ(bit sel);
    return sel ? if_b.occupancy : if_a.occupancy;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic run_vec(bit sel, vec_t v, int idx);
    string tag;
    tag = $sformatf("%s[%0d]", sel ? "vec_b" : "vec_a", idx);
    drive(sel, v.fl, v.iv, v.d, v.ordy);
    #1;
    chk({tag, ".in_ready"}, 32'(g_rdy(sel)), 32'(v.x_rdy));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(g_ov(sel)), 32'(v.x_ov));
    chk({tag, ".out_data"},  32'(g_od(sel)), 32'(v.x_od));
    chk({tag, ".occupancy"}, 32'(g_occ(sel)), 32'(v.x_occ));
  endtask

  task automatic run_random(bit sel, int cycles);
    logic [W-1:0] q[$];
    logic fl, iv, ordy, x_rdy, psh, pp;
    logic [W-1:0] d;
    for (int c = 0; c < cycles; c++) begin
      fl   = ($urandom_range(0, 31) == 0);
      iv   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 2) != 0);
      d    = W'($urandom);
      drive(sel, fl, iv, d, ordy);
      #1;
      x_rdy = sel ? (q.size() == 0 || ordy) : (q.size() < 2);
      chk("rnd.in_ready",  32'(g_rdy(sel)), 32'(x_rdy));
      chk("rnd.out_valid", 32'(g_ov(sel)),  32'(q.size() != 0));
      chk("rnd.out_data",  32'(g_od(sel)),  32'(q.size() != 0 ? q[0] : RV));
      chk("rnd.occupancy", 32'(g_occ(sel)), 32'(q.size()));
      psh = iv & x_rdy;
      pp  = (q.size() != 0) & ordy;
      @(posedge clk); #1;
      if (fl) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (psh) q.push_back(d);
      end
    end
    drive(sel, 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // SKID=1: streaming, backpressure, flush
    for (int i = 1; i <= 8; i++)
      tab_a.push_back(mk(0, 1, W'(i), 1, 1, 1, W'(i), 2'd1));
    tab_a.push_back(mk(0, 0, 16'h0000, 1, 1, 0, RV, 2'd0));
    tab_a.push_back(mk(0, 1, 16'h000A, 0, 1, 1, 16'h000A, 2'd1));
    tab_a.push_back(mk(0, 1, 16'h000B, 0, 1, 1, 16'h000A, 2'd2));
    tab_a.push_back(mk(0, 1, 16'h000C, 0, 0, 1, 16'h000A, 2'd2));
    tab_a.push_back(mk(0, 1, 16'h000C, 0, 0, 1, 16'h000A, 2'd2));
    tab_a.push_back(mk(0, 1, 16'h000C, 1, 0, 1, 16'h000B, 2'd1));
    tab_a.push_back(mk(0, 1, 16'h000C, 1, 1, 1, 16'h000C, 2'd1));
    tab_a.push_back(mk(0, 0, 16'h0000, 1, 1, 0, RV, 2'd0));
    tab_a.push_back(mk(0, 1, 16'h0011, 0, 1, 1, 16'h0011, 2'd1));
    tab_a.push_back(mk(0, 1, 16'h0012, 0, 1, 1, 16'h0011, 2'd2));
    tab_a.push_back(mk(1, 1, 16'h000D, 0, 0, 0, RV, 2'd0));
    tab_a.push_back(mk(0, 0, 16'h0000, 1, 1, 0, RV, 2'd0));
    tab_a.push_back(mk(0, 1, 16'h0013, 0, 1, 1, 16'h0013, 2'd1));
    tab_a.push_back(mk(1, 1, 16'h000E, 1, 1, 0, RV, 2'd0));
    tab_a.push_back(mk(0, 0, 16'h0000, 1, 1, 0, RV, 2'd0));

    // SKID=0: combinational ready, replace on push&pop, flush
    tab_b.push_back(mk(0, 1, 16'h0033, 0, 1, 1, 16'h0033, 2'd1));
    tab_b.push_back(mk(0, 1, 16'h0044, 0, 0, 1, 16'h0033, 2'd1));
    tab_b.push_back(mk(0, 1, 16'h0005, 1, 1, 1, 16'h0005, 2'd1));
    tab_b.push_back(mk(0, 1, 16'h0006, 1, 1, 1, 16'h0006, 2'd1));
    tab_b.push_back(mk(0, 0, 16'h0000, 1, 1, 0, RV, 2'd0));
    tab_b.push_back(mk(0, 1, 16'h0066, 0, 1, 1, 16'h0066, 2'd1));
    tab_b.push_back(mk(1, 1, 16'h0077, 0, 0, 0, RV, 2'd0));
    tab_b.push_back(mk(0, 0, 16'h0000, 0, 1, 0, RV, 2'd0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.a.out_valid", 32'(if_a.out_valid), 32'(0));
    chk("reset.a.out_data",  32'(if_a.out_data),  32'(RV));
    chk("reset.a.occupancy", 32'(if_a.occupancy), 32'(0));
    chk("reset.a.in_ready",  32'(if_a.in_ready),  32'(1));
    chk("reset.b.in_ready",  32'(if_b.in_ready),  32'(1));
    chk("reset.b.out_data",  32'(if_b.out_data),  32'(RV));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tab_a[i]) run_vec(1'b0, tab_a[i], i);

    // Asynchronous reset while holding two entries
    drive(1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0022, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("async.pre.occupancy", 32'(if_a.occupancy), 32'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("async.out_valid", 32'(if_a.out_valid), 32'(0));
    chk("async.out_data",  32'(if_a.out_data),  32'(RV));
    chk("async.occupancy", 32'(if_a.occupancy), 32'(0));
    chk("async.in_ready",  32'(if_a.in_ready),  32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_random(1'b0, 10000);

    foreach (tab_b[i]) run_vec(1'b1, tab_b[i], i);

    run_random(1'b1, 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
